// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared addresses, response codes, status layout and TX FSM states
package uart_tx_mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEFAULT     = 32'h8000_0004;
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h8000_0008;

    localparam int BUS_RESP_WIDTH = 1;
    localparam logic [BUS_RESP_WIDTH-1:0] RESP_OK    = 1'b0;
    localparam logic [BUS_RESP_WIDTH-1:0] RESP_ERROR = 1'b1;

    // Status word layout; the FIFO count field starts at STATUS_COUNT_LSB
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_COUNT_LSB = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow so the pointers can never corrupt state
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - bus-attached 8N1 UART transmitter with TX FIFO and status register
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] TX_ADDR      = BUS_WIDTH'(TX_ADDR_DEFAULT),
    parameter logic [BUS_WIDTH-1:0] STATUS_ADDR  = BUS_WIDTH'(STATUS_ADDR_DEFAULT),
    parameter int                   CLKS_PER_BIT = 16,
    parameter int                   FIFO_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dw_data_addr_valid,
    output logic                      dw_data_addr_ready,
    input  logic [BUS_WIDTH-1:0]      dw_addr,
    input  logic [BUS_WIDTH-1:0]      dw_data,
    input  logic [BUS_WIDTH/8-1:0]    dw_strobe,
    output logic                      dw_resp_valid,
    input  logic                      dw_resp_ready,
    output logic [BUS_RESP_WIDTH-1:0] dw_resp,
    input  logic                      dr_addr_valid,
    output logic                      dr_addr_ready,
    input  logic [BUS_WIDTH-1:0]      dr_addr,
    output logic                      dr_data_valid,
    input  logic                      dr_data_ready,
    output logic [BUS_WIDTH-1:0]      dr_data,
    output logic                      uart_tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic [CNT_W-1:0] fifo_count;

    logic             addr_is_tx;
    logic             wr_accept;
    logic             wr_push;
    logic             rd_accept;
    logic [BUS_WIDTH-1:0] status_word;

    tx_state_t        state;
    tx_state_t        state_next;
    logic [TMR_W-1:0] bit_tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;
    logic             tx_busy;

    // Only the low data byte and byte lane 0 enable carry meaning here
    logic             unused_bits;
    assign unused_bits = ^{dw_data[BUS_WIDTH-1:8], dw_strobe[BUS_WIDTH/8-1:1]};

    // ------------------------------------------------------------------
    // Write channel: one outstanding response; a full FIFO stalls only TX writes
    // ------------------------------------------------------------------
    assign addr_is_tx         = (dw_addr == TX_ADDR);
    assign dw_data_addr_ready = rst & ~dw_resp_valid & ~(addr_is_tx & fifo_full);
    assign wr_accept          = dw_data_addr_valid & dw_data_addr_ready;
    assign wr_push            = wr_accept & addr_is_tx & dw_strobe[0];

    // Registered write response, held until the requester consumes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            dw_resp_valid <= 1'b0;
            dw_resp       <= RESP_OK;
        end else if (wr_accept) begin
            dw_resp_valid <= 1'b1;
            dw_resp       <= addr_is_tx ? RESP_OK : RESP_ERROR;
        end else if (dw_resp_valid && dw_resp_ready) begin
            dw_resp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read channel: status captured at acceptance, so a same-cycle pop is not seen
    // ------------------------------------------------------------------
    assign dr_addr_ready = rst & ~dr_data_valid;
    assign rd_accept     = dr_addr_valid & dr_addr_ready;

    // Assemble the status word from live FIFO and transmitter state
    always_comb begin
        status_word = '0;
        status_word[STATUS_EMPTY_BIT]              = fifo_empty;
        status_word[STATUS_FULL_BIT]               = fifo_full;
        status_word[STATUS_BUSY_BIT]               = tx_busy;
        status_word[STATUS_COUNT_LSB +: CNT_W]     = fifo_count;
    end

    // Registered read data, held until the requester consumes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            dr_data_valid <= 1'b0;
            dr_data       <= '0;
        end else if (rd_accept) begin
            dr_data_valid <= 1'b1;
            dr_data       <= (dr_addr == STATUS_ADDR) ? status_word : '0;
        end else if (dr_data_valid && dr_data_ready) begin
            dr_data_valid <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_push),
        .push_data (dw_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    assign bit_end = (bit_tmr == TMR_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: each non-idle state lasts whole bit periods
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (!fifo_empty) state_next = TX_START;
            TX_START: if (bit_end) state_next = TX_DATA;
            TX_DATA:  if (bit_end && bit_idx == 3'd7) state_next = TX_STOP;
            TX_STOP:  if (bit_end) state_next = TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    // FSM outputs: line level, FIFO pop on leaving idle, busy flag
    always_comb begin
        uart_tx  = 1'b1;
        fifo_pop = 1'b0;
        tx_busy  = 1'b1;
        case (state)
            TX_IDLE: begin
                tx_busy  = 1'b0;
                fifo_pop = ~fifo_empty;
            end
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = shift_reg[0];
            TX_STOP:  uart_tx = 1'b1;
            default:  uart_tx = 1'b1;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_tmr   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (state == TX_IDLE) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            if (fifo_pop) begin
                shift_reg <= fifo_rd_data;
            end
        end else if (bit_end) begin
            bit_tmr <= '0;
            if (state == TX_DATA) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end else begin
            bit_tmr <= bit_tmr + TMR_W'(1);
        end
    end

endmodule
